cla16_rr_share: RTL and testbench
=================================

# cla16_rr_share

Round-robin arbiter and pipeline controller that time-shares one CLA16 carry-lookahead adder between N_REQ requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester per cycle, registers the operands, and runs them through the shared CLA16 with Ci tied to 0. It returns the sum, the carry-out and the requester ID on a single back-pressurable response channel. It replaces per-requester adders in the MAC datapath where adder area dominates.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- IDW, default 2: ID width, equal to clog2(N_REQ).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  bit i means requester i presents operands.
- req_a  in  16*N_REQ  operand A, requester i at bits [16i+15:16i].
- req_b  in  16*N_REQ  operand B, packed the same way.
- req_ready  out  N_REQ  one-hot or zero; bit i means requester i is accepted this cycle.
- rsp_valid  out  1  response holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  16  (A+B) mod 2^16.
- rsp_cout  out  1  carry-out of A+B.
- rsp_id  out  IDW  index of the originating requester.

## Operation
- Reset value of every output is 0.
- Reset clears all internal state: the S1 and S2 valid flags, the operand/ID/result registers, and the round-robin pointer (pointer = 0, so requester 0 has top priority).
- Pipeline stages:
  - S1: operand registers A_r, B_r, id1, v1.
  - Combinational CLA16 between S1 and S2.
  - S2: result registers rsp_sum, rsp_cout, rsp_id, with rsp_valid = v2.
- Stall logic:
  - s2_adv = !v2 | rsp_ready.
  - s1_adv = !v1 | s2_adv.
  - accept = s1_adv & (|req_valid).
- Arbitration:
  - Candidate order is ptr, ptr+1, …, wrapping mod N_REQ.
  - The grant g is the first candidate with req_valid set.
  - req_ready[g] = accept. All other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr and the pipeline state. It never depends on req_a or req_b.
- On accept:
  - A_r <= req_a[g], B_r <= req_b[g], id1 <= g, v1 <= 1.
  - ptr <= (g+1) mod N_REQ.
- If s1_adv and no request is present: v1 <= 0, ptr unchanged.
- If s2_adv: S2 loads the CLA16 output (sum, cout) and id1, and v2 <= v1.
- If !s2_adv: S2 holds and S1 holds.
- Requester rules:
  - Once a requester asserts req_valid, it holds req_valid and its operands stable until it sees req_ready.
  - A requester may withdraw only after it has been accepted.
- The block issues no speculative grants and never drops a request.
- Ordering: responses leave in acceptance order. There is no reordering.
- The pointer advances only on an actual grant. A requester that is continuously valid is served within N_REQ grants.
- Arithmetic: unsigned 16-bit add with Ci = 0. Overflow wraps and is reported on rsp_cout. No saturation.

## Timing
- Latency: a request accepted at edge k (req_ready high in cycle k-1 → sampled at edge k) appears with rsp_valid = 1 after edge k+1, provided there is no back-pressure.
- Throughput: one result per cycle while rsp_ready = 1 and any request is valid.
- Back-pressure:
  - If rsp_ready = 0 while rsp_valid = 1, S2 holds its values unchanged.
  - S1 may still fill if it is empty. Once S1 and S2 are both full, all req_ready bits drop in the same cycle.
- rsp_valid stays high and rsp_sum, rsp_cout and rsp_id stay stable until the edge at which rsp_ready = 1.
- Simultaneous events:
  - Under back-pressure, the S2 handoff and a new grant in the same cycle are legal. S1 loads the new operands only when S1 is advancing.
  - A pointer update and a grant in the same cycle use the pre-update pointer for selection.
- Reset asserted mid-operation clears both stages immediately (asynchronously). In-flight results are discarded with no response. The first grant after release goes to the lowest-index valid requester.
- Maximum capacity is 2 in-flight results. The block has no internal FIFO.

## Test plan
- Single request: requester 2 sends A=0x1234, B=0x4321. req_ready[2] is high in the same cycle. Two edges later: rsp_valid=1, rsp_sum=0x5555, rsp_cout=0, rsp_id=2.
- Overflow: A=0xFFFF, B=0x0001 → rsp_sum=0x0000, rsp_cout=1. A=0x8000, B=0x8000 → rsp_sum=0x0000, rsp_cout=1.
- Fairness: all 4 requesters hold valid continuously and rsp_ready=1. Grants and rsp_id run 0,1,2,3,0,1,… with one result per cycle and no gaps.
- Back-pressure: stream from requester 0, drop rsp_ready for 5 cycles.
  - rsp_* stays frozen for those cycles.
  - req_ready goes to 0 after one more acceptance.
  - After rsp_ready returns, there is no loss or duplication: the sequence of sums matches the sequence of inputs.
- Sparse requests: requesters 1 and 3 only, ptr=2 → requester 3 is granted first, then 1. Requesters 0 and 2 never receive req_ready.
- Reset mid-flight: two results in flight, assert rst for 1 cycle.
  - All outputs go to 0 with no response emitted.
  - After release with requesters 0 and 3 valid, requester 0 is granted first.

Source files
------------

// File: rtl/cla16_rr_share.sv
// Round-robin share of one 16-bit carry-lookahead adder between N_REQ requesters.
// Two-stage pipeline: operand capture (S1), then result registers (S2) on a back-pressurable channel.
module cla16_rr_share #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic [IDW-1:0]       rsp_id
);
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [IDW-1:0]     r_id1;
    logic               r_v1;
    logic [15:0]        r_sum;
    logic               r_cout;
    logic [IDW-1:0]     r_id2;
    logic               r_v2;
    logic [IDW-1:0]     r_ptr;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_accept;
    logic [2*N_REQ-1:0] w_dbl;
    logic [2*N_REQ-1:0] w_shift;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    int unsigned        w_idx;
    logic [IDW-1:0]     w_gnt;
    logic [IDW-1:0]     w_ptr_nxt;
    logic [15:0]        w_a_sel;
    logic [15:0]        w_b_sel;

    logic [15:0]        w_p;
    logic [15:0]        w_g;
    logic [3:0]         w_gg;
    logic [3:0]         w_gp;
    logic [4:0]         w_gc;
    logic [16:0]        w_c;
    logic [15:0]        w_sum;
    logic               w_cout;

    assign w_s2_adv = !r_v2 || rsp_ready;
    assign w_s1_adv = !r_v1 || w_s2_adv;
    assign w_accept = w_s1_adv && (|req_valid);

    // Rotate the request vector so bit 0 is the requester at the pointer.
    assign w_dbl   = {req_valid, req_valid};
    assign w_shift = w_dbl >> r_ptr;
    assign w_rot   = w_shift[N_REQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_idx   = 0;
        w_gnt   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_idx   = 32'(r_ptr) + k;
                if (w_idx >= N_REQ) begin
                    w_idx = w_idx - N_REQ;
                end
                w_gnt = IDW'(w_idx);
            end
        end
    end

    assign w_ptr_nxt = (32'(w_gnt) == N_REQ - 1) ? '0 : w_gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (IDW'(k) == w_gnt) begin
                w_a_sel = req_a[16*k +: 16];
                w_b_sel = req_b[16*k +: 16];
            end
        end
    end

    // Two-level lookahead: 4-bit groups with group G/P, carry-in fixed at 0.
    always_comb begin
        w_p = r_a ^ r_b;
        w_g = r_a & r_b;
        for (int unsigned j = 0; j < 4; j++) begin
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gp[j] = &w_p[4*j +: 4];
        end
        w_gc[0] = 1'b0;
        w_gc[1] = w_gg[0];
        w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]);
        w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0]);
        w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);
        w_c = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            w_c[4*j]   = w_gc[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
        end
        w_c[16] = w_gc[4];
        w_sum   = w_p ^ w_c[15:0];
        w_cout  = w_c[16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_id1  <= '0;
            r_v1   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_id2  <= '0;
            r_v2   <= 1'b0;
            r_ptr  <= '0;
        end else begin
            if (w_s2_adv) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_id2  <= r_id1;
                r_v2   <= r_v1;
            end
            if (w_s1_adv) begin
                if (w_accept) begin
                    r_a   <= w_a_sel;
                    r_b   <= w_b_sel;
                    r_id1 <= w_gnt;
                    r_v1  <= 1'b1;
                    r_ptr <= w_ptr_nxt;
                end else begin
                    r_v1  <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_v2;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_id    = r_id2;
endmodule

// File: tb/tb_cla16_rr_share.sv
// Scoreboard bench for cla16_rr_share: requester models feed queued vectors, a monitor
// pushes the expected result on every handshake and pops/compares on every response.
module tb_cla16_rr_share;
    localparam int NR = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        c;
    } req_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] s;
        logic        c;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [16*NR-1:0]  req_a = '0;
    logic [16*NR-1:0]  req_b = '0;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [15:0]       rsp_sum;
    logic              rsp_cout;
    logic [1:0]        rsp_id;

    req_t          pend [NR][$];
    exp_t          sbq[$];
    int            gntlog[$];
    int            stamps[$];
    logic [NR-1:0] hs = '0;
    logic [NR-1:0] ready_seen = '0;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    cla16_rr_share #(.N_REQ(NR), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] s, input logic c);
        req_t r;
        r.a = a;
        r.b = b;
        r.s = s;
        r.c = c;
        pend[i].push_back(r);
    endtask

    task automatic push_auto(input int i, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b};
        push(i, a, b, t[15:0], t[16]);
    endtask

    function automatic int pend_cnt();
        int t = 0;
        for (int i = 0; i < NR; i++) t += pend[i].size();
        return t;
    endfunction

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || pend_cnt() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", sbq.size() + pend_cnt(), 0);
        @(posedge clk);
        #2;
    endtask

    // Requester models: hold operands until accepted, then present the next queued pair.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) void'(pend[i].pop_front());
                if (pend[i].size() != 0) begin
                    req_valid[i]      = 1'b1;
                    req_a[16*i +: 16] = pend[i][0].a;
                    req_b[16*i +: 16] = pend[i][0].b;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: sampled mid-cycle, away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                ready_seen |= req_ready;
                if (rsp_valid && rsp_ready) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_sum", rsp_sum, e.s);
                        chk("rsp_cout", rsp_cout, e.c);
                        stamps.push_back(cyc);
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    hs[i] = req_valid[i] && req_ready[i];
                    if (hs[i]) begin
                        e.id = 2'(i);
                        e.s  = pend[i][0].s;
                        e.c  = pend[i][0].c;
                        sbq.push_back(e);
                        gntlog.push_back(i);
                    end
                end
            end else begin
                hs = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid", rsp_valid, 0);
        chk("reset_sum", rsp_sum, 0);
        chk("reset_cout", rsp_cout, 0);
        chk("reset_id", rsp_id, 0);
        chk("reset_ready", req_ready, 0);
        rst = 1'b0;

        // Single request from requester 2
        @(negedge clk);
        push(2, 16'h1234, 16'h4321, 16'h5555, 1'b0);
        @(posedge clk); #2;
        chk("single_ready", req_ready, 4'b0100);
        @(posedge clk); #2;
        chk("single_lat_early", rsp_valid, 0);
        @(posedge clk); #2;
        chk("single_valid", rsp_valid, 1);
        chk("single_sum", rsp_sum, 16'h5555);
        chk("single_cout", rsp_cout, 0);
        chk("single_id", rsp_id, 2);
        drain();

        // Overflow wraps and reports carry
        @(negedge clk);
        push(1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        push(1, 16'h8000, 16'h8000, 16'h0000, 1'b1);
        drain();

        // Sparse: pointer is at 2, so 3 goes before 1
        @(negedge clk);
        ready_seen = '0;
        gntlog.delete();
        push(1, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);
        push(3, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        drain();
        chk("sparse_cnt", gntlog.size(), 2);
        if (gntlog.size() >= 2) begin
            chk("sparse_first", gntlog[0], 3);
            chk("sparse_second", gntlog[1], 1);
        end
        chk("sparse_never_0_2", ready_seen & 4'b0101, 0);

        // Move pointer back to 0
        @(negedge clk);
        push(3, 16'h0001, 16'h0002, 16'h0003, 1'b0);
        drain();

        // Fairness: all four continuously valid
        @(negedge clk);
        gntlog.delete();
        stamps.delete();
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NR; i++) begin
                push_auto(i, 16'(16'h3000 * i + j), 16'(16'hE100 + 16'h0011 * i));
            end
        end
        drain();
        chk("fair_cnt", gntlog.size(), 8);
        if (gntlog.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("fair_gnt", gntlog[k], k % 4);
        end
        if (stamps.size() >= 8) begin
            chk("fair_no_gaps", stamps[7] - stamps[0], 7);
        end

        // Back-pressure on a stream from requester 0
        @(negedge clk);
        rsp_ready = 1'b0;
        gntlog.delete();
        push(0, 16'h1000, 16'h0001, 16'h1001, 1'b0);
        for (int k = 1; k < 6; k++) push_auto(0, 16'(16'h2000 * k), 16'hF00F);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("bp_wait", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_sum", rsp_sum, 16'h1001);
            chk("bp_hold_id", rsp_id, 0);
            chk("bp_ready_low", req_ready, 0);
            @(posedge clk); #2;
        end
        chk("bp_accepts", gntlog.size(), 2);
        rsp_ready = 1'b1;
        drain();

        // Reset with two results in flight
        @(negedge clk);
        rsp_ready = 1'b0;
        gntlog.delete();
        push(1, 16'h0001, 16'h0001, 16'h0002, 1'b0);
        push(1, 16'h0003, 16'h0003, 16'h0006, 1'b0);
        n = 0;
        while (gntlog.size() < 2 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rst_inflight", gntlog.size(), 2);
        rst = 1'b1;
        #1;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_cout", rsp_cout, 0);
        chk("rst_id", rsp_id, 0);
        sbq.delete();
        gntlog.delete();
        push(0, 16'h0005, 16'h0005, 16'h000A, 1'b0);
        push(3, 16'h0006, 16'h0006, 16'h000C, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_no_rsp", rsp_valid, 0);
        chk("rst_first_ready", req_ready, 4'b0001);
        drain();
        chk("rst_cnt", gntlog.size(), 2);
        if (gntlog.size() >= 2) begin
            chk("rst_first_gnt", gntlog[0], 0);
            chk("rst_second_gnt", gntlog[1], 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
